// File: rtl/dcpu16_pkg.sv
// ============================================================================
// Module : dcpu16_pkg
// Desc   : Shared opcode, phase and operand-code constants for the dcpu16 core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dcpu16_pkg;

  typedef logic [3:0] opc_t;
  typedef logic [1:0] pha_t;

  localparam opc_t OPC_NBI = 4'h0;
  localparam opc_t OPC_SET = 4'h1;
  localparam opc_t OPC_ADD = 4'h2;
  localparam opc_t OPC_SUB = 4'h3;
  localparam opc_t OPC_MUL = 4'h4;
  localparam opc_t OPC_DIV = 4'h5;
  localparam opc_t OPC_MOD = 4'h6;
  localparam opc_t OPC_SHL = 4'h7;
  localparam opc_t OPC_SHR = 4'h8;
  localparam opc_t OPC_AND = 4'h9;
  localparam opc_t OPC_BOR = 4'hA;
  localparam opc_t OPC_XOR = 4'hB;
  localparam opc_t OPC_IFE = 4'hC;
  localparam opc_t OPC_IFN = 4'hD;
  localparam opc_t OPC_IFG = 4'hE;
  localparam opc_t OPC_IFB = 4'hF;

  localparam pha_t PHA_0 = 2'd0;
  localparam pha_t PHA_1 = 2'd1;
  localparam pha_t PHA_2 = 2'd2;
  localparam pha_t PHA_3 = 2'd3;

  localparam logic [5:0] O_REG = 6'h1D;

  function automatic logic is_if(input opc_t op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcpu16_alu_arith.sv
// ============================================================================
// Module : dcpu16_alu_arith
// Desc   : Combinational opcode evaluation: result, overflow value and enables.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcpu16_alu_arith
  import dcpu16_pkg::*;
(
  input  logic [3:0]  opc_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] res_o,
  output logic [15:0] ovf_o,
  output logic        ovf_we_o,
  output logic        cond_true_o,
  output logic        wr_en_o
);

  logic [16:0] w_sum;
  logic [31:0] w_prod;
  logic [31:0] w_div;
  logic [31:0] w_shl;
  logic [31:0] w_shr;
  logic        w_big_shift;

  assign w_sum       = {1'b0, a_i} + {1'b0, b_i};
  assign w_prod      = {16'h0, a_i} * {16'h0, b_i};
  assign w_div       = (b_i == 16'h0) ? 32'h0 : ({a_i, 16'h0} / {16'h0, b_i});
  assign w_big_shift = (b_i[15:5] != 11'h0);
  // A 32-bit window holds every bit that can reach res or O for shifts < 32.
  assign w_shl       = {16'h0, a_i} << b_i[4:0];
  assign w_shr       = {a_i, 16'h0} >> b_i[4:0];

  always_comb begin
    res_o       = 16'h0;
    ovf_o       = 16'h0;
    ovf_we_o    = 1'b0;
    cond_true_o = 1'b0;
    wr_en_o     = 1'b1;
    unique case (opc_i)
      OPC_NBI: begin res_o = a_i; wr_en_o = 1'b0; end
      OPC_SET: res_o = b_i;
      OPC_ADD: begin res_o = w_sum[15:0]; ovf_o = {15'h0, w_sum[16]}; ovf_we_o = 1'b1; end
      OPC_SUB: begin
        res_o    = a_i - b_i;
        ovf_o    = (a_i < b_i) ? 16'hFFFF : 16'h0000;
        ovf_we_o = 1'b1;
      end
      OPC_MUL: begin res_o = w_prod[15:0]; ovf_o = w_prod[31:16]; ovf_we_o = 1'b1; end
      OPC_DIV: begin
        res_o    = (b_i == 16'h0) ? 16'h0 : (a_i / b_i);
        ovf_o    = w_div[15:0];
        ovf_we_o = 1'b1;
      end
      OPC_MOD: res_o = (b_i == 16'h0) ? 16'h0 : (a_i % b_i);
      OPC_SHL: begin
        res_o    = w_big_shift ? 16'h0 : w_shl[15:0];
        ovf_o    = w_big_shift ? 16'h0 : w_shl[31:16];
        ovf_we_o = 1'b1;
      end
      OPC_SHR: begin
        res_o    = w_big_shift ? 16'h0 : w_shr[31:16];
        ovf_o    = w_big_shift ? 16'h0 : w_shr[15:0];
        ovf_we_o = 1'b1;
      end
      OPC_AND: res_o = a_i & b_i;
      OPC_BOR: res_o = a_i | b_i;
      OPC_XOR: res_o = a_i ^ b_i;
      OPC_IFE: begin wr_en_o = 1'b0; cond_true_o = (a_i == b_i); end
      OPC_IFN: begin wr_en_o = 1'b0; cond_true_o = (a_i != b_i); end
      OPC_IFG: begin wr_en_o = 1'b0; cond_true_o = (a_i > b_i); end
      OPC_IFB: begin wr_en_o = 1'b0; cond_true_o = ((a_i & b_i) != 16'h0); end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dcpu16_alu.sv
// ============================================================================
// Module : dcpu16_alu
// Desc   : dcpu16 execute stage: operand latches, O register, skip and wre.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcpu16_alu
  import dcpu16_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [1:0]    pha,
  input  logic [3:0]    opc,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic          owe,
  input  logic [DW-1:0] odi,
  output logic [DW-1:0] res,
  output logic          wre,
  output logic [DW-1:0] reo,
  output logic          skp
);

  logic [3:0]    opc_q;
  logic [DW-1:0] opa_q;
  logic [DW-1:0] opb_q;
  logic [DW-1:0] res_q;
  logic [DW-1:0] reo_q;
  logic          wre_q;
  logic          skp_q;

  logic [15:0] w_res;
  logic [15:0] w_ovf;
  logic        w_ovf_we;
  logic        w_cond_true;
  logic        w_wr_en;

  dcpu16_alu_arith u_arith (
    .opc_i       (opc_q),
    .a_i         (opa_q),
    .b_i         (opb_q),
    .res_o       (w_res),
    .ovf_o       (w_ovf),
    .ovf_we_o    (w_ovf_we),
    .cond_true_o (w_cond_true),
    .wr_en_o     (w_wr_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      reo_q <= '0;
      wre_q <= 1'b0;
      skp_q <= 1'b0;
    end else if (ena) begin
      if (pha == PHA_3) begin
        opc_q <= opc;
        opa_q <= opa;
        opb_q <= opb;
      end
      if (pha != PHA_0) begin
        wre_q <= 1'b0;
      end else if (skp_q) begin
        // Discarded instruction: consume the skip, never evaluate it.
        wre_q <= 1'b0;
        skp_q <= 1'b0;
      end else begin
        res_q <= w_res;
        wre_q <= w_wr_en;
        if (owe)
          reo_q <= odi;
        else if (w_ovf_we)
          reo_q <= w_ovf;
        if (is_if(opc_q) && !w_cond_true)
          skp_q <= 1'b1;
      end
    end
  end

  assign res = res_q;
  assign wre = wre_q;
  assign reo = reo_q;
  assign skp = skp_q;

endmodule

`default_nettype wire

// File: tb/tb_dcpu16_alu.sv
// ============================================================================
// Module : tb_dcpu16_alu
// Desc   : Directed self-checking bench for the dcpu16 execute stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcpu16_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [1:0]  pha = 2'd0;
  logic [3:0]  opc = 4'h0;
  logic [15:0] opa = 16'h0;
  logic [15:0] opb = 16'h0;
  logic        owe = 1'b0;
  logic [15:0] odi = 16'h0;
  logic [15:0] res;
  logic        wre;
  logic [15:0] reo;
  logic        skp;

  int checks = 0;
  int errors = 0;

  dcpu16_alu #(.DW(16)) dut (
    .clk (clk), .rst (rst), .ena (ena), .pha (pha),
    .opc (opc), .opa (opa), .opb (opb), .owe (owe), .odi (odi),
    .res (res), .wre (wre), .reo (reo), .skp (skp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    pha = 2'd3; opc = o; opa = a; opb = b;
    tick();
  endtask

  task automatic execute(input logic ow, input logic [15:0] od);
    pha = 2'd0; owe = ow; odi = od;
    tick();
    owe = 1'b0; pha = 2'd1;
  endtask

  task automatic tail(input string tag);
    tick();
    chk({tag, "_wre_clr"}, {15'h0, wre}, 16'h0);
    pha = 2'd2;
    tick();
  endtask

  task automatic instr(input string tag, input logic [3:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic ow, input logic [15:0] od,
                       input logic [15:0] e_res, input logic e_wre,
                       input logic [15:0] e_reo, input logic e_skp);
    latch(o, a, b);
    execute(ow, od);
    chk({tag, "_res"}, res, e_res);
    chk({tag, "_wre"}, {15'h0, wre}, {15'h0, e_wre});
    chk({tag, "_reo"}, reo, e_reo);
    chk({tag, "_skp"}, {15'h0, skp}, {15'h0, e_skp});
    tail(tag);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_res", res, 16'h0);
    chk("rst_wre", {15'h0, wre}, 16'h0);
    chk("rst_reo", reo, 16'h0);
    chk("rst_skp", {15'h0, skp}, 16'h0);

    instr("add_c",  4'h2, 16'hFFFF, 16'h0002, 1'b0, 16'h0, 16'h0001, 1'b1, 16'h0001, 1'b0);
    instr("sub_b",  4'h3, 16'h0001, 16'h0002, 1'b0, 16'h0, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0);
    instr("and",    4'h9, 16'hF0F0, 16'h0FF0, 1'b0, 16'h0, 16'h00F0, 1'b1, 16'hFFFF, 1'b0);
    instr("bor",    4'hA, 16'hF000, 16'h000F, 1'b0, 16'h0, 16'hF00F, 1'b1, 16'hFFFF, 1'b0);
    instr("mul",    4'h4, 16'h1234, 16'h0100, 1'b0, 16'h0, 16'h3400, 1'b1, 16'h0012, 1'b0);
    instr("div",    4'h5, 16'h0001, 16'h0002, 1'b0, 16'h0, 16'h0000, 1'b1, 16'h8000, 1'b0);
    instr("div0",   4'h5, 16'h0007, 16'h0000, 1'b0, 16'h0, 16'h0000, 1'b1, 16'h0000, 1'b0);
    instr("shl",    4'h7, 16'h8001, 16'h0001, 1'b0, 16'h0, 16'h0002, 1'b1, 16'h0001, 1'b0);
    instr("shr",    4'h8, 16'h0003, 16'h0001, 1'b0, 16'h0, 16'h0001, 1'b1, 16'h8000, 1'b0);
    instr("mod",    4'h6, 16'h0007, 16'h0003, 1'b0, 16'h0, 16'h0001, 1'b1, 16'h8000, 1'b0);
    instr("mod0",   4'h6, 16'h0005, 16'h0000, 1'b0, 16'h0, 16'h0000, 1'b1, 16'h8000, 1'b0);
    instr("shl40",  4'h7, 16'hFFFF, 16'd40,   1'b0, 16'h0, 16'h0000, 1'b1, 16'h0000, 1'b0);
    instr("nbi",    4'h0, 16'h4321, 16'h1111, 1'b0, 16'h0, 16'h4321, 1'b0, 16'h0000, 1'b0);

    // Skip behaviour: failed IF, skipped SET, then a normal SET.
    instr("ife_f",  4'hC, 16'h0001, 16'h0002, 1'b0, 16'h0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    instr("set_sk", 4'h1, 16'h0000, 16'hABCD, 1'b0, 16'h0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    instr("set",    4'h1, 16'h0000, 16'h1234, 1'b0, 16'h0, 16'h1234, 1'b1, 16'h0000, 1'b0);
    instr("ifn_f",  4'hD, 16'h0005, 16'h0005, 1'b0, 16'h0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    instr("ifn_sk", 4'hD, 16'h0003, 16'h0003, 1'b0, 16'h0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    instr("ifg_t",  4'hE, 16'h0003, 16'h0002, 1'b0, 16'h0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    instr("ifb_f",  4'hF, 16'h00F0, 16'h000F, 1'b0, 16'h0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    instr("xor_sk", 4'hB, 16'h00FF, 16'h0F0F, 1'b1, 16'h1111, 16'h0000, 1'b0, 16'h0000, 1'b0);
    instr("xor",    4'hB, 16'h00FF, 16'h0F0F, 1'b0, 16'h0, 16'h0FF0, 1'b1, 16'h0000, 1'b0);

    // Explicit O write overrides the ADD carry update.
    instr("add_owe", 4'h2, 16'hFFFF, 16'h0002, 1'b1, 16'h5555, 16'h0001, 1'b1, 16'h5555, 1'b0);

    // ena held low across the execute edge, then across a wre-high cycle.
    latch(4'h3, 16'h0005, 16'h0001);
    pha = 2'd0; ena = 1'b0;
    tick(); tick(); tick();
    chk("ena_hold_res", res, 16'h0001);
    chk("ena_hold_reo", reo, 16'h5555);
    chk("ena_hold_wre", {15'h0, wre}, 16'h0);
    ena = 1'b1;
    execute(1'b0, 16'h0);
    chk("ena_sub_res", res, 16'h0004);
    chk("ena_sub_reo", reo, 16'h0000);
    chk("ena_sub_wre", {15'h0, wre}, 16'h1);
    ena = 1'b0;
    tick(); tick(); tick();
    chk("ena_wre_hold", {15'h0, wre}, 16'h1);
    chk("ena_res_hold", res, 16'h0004);
    ena = 1'b1;
    tail("ena_resume");

    // Reset mid-instruction drops a pending skip.
    instr("ife_f2", 4'hC, 16'h0001, 16'h0002, 1'b0, 16'h0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    latch(4'h2, 16'h7000, 16'h9000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_skp", {15'h0, skp}, 16'h0);
    chk("mrst_reo", reo, 16'h0);
    instr("post_rst", 4'h1, 16'h0, 16'h0007, 1'b0, 16'h0, 16'h0007, 1'b1, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcpu16_alu.md
Name: dcpu16_alu

Overview:
- Execute stage directly downstream of the dcpu16 control/decode block.
- Consumes the 4-bit basic opcode and the two resolved operand values, then computes the result and the write-enable for the destination.
- Maintains the architectural overflow register O and the conditional-skip flag used by the IFx instructions.
- Runs in lock-step with the 4-phase instruction cycle (pha) driven by the control block.

Parameters:
- DW, 16, data path width; only 16 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- ena  in  1  global clock enable; all state holds when low
- pha  in  2  instruction phase from the control block (0..3, wraps)
- opc  in  4  basic opcode (0 non-basic, 1 SET, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 MOD, 7 SHL, 8 SHR, 9 AND, A BOR, B XOR, C IFE, D IFN, E IFG, F IFB)
- opa  in  16  operand a value (destination's current value)
- opb  in  16  operand b value
- owe  in  1  explicit write of O (destination operand is O)
- odi  in  16  data for explicit O write
- res  out  16  registered ALU result
- wre  out  1  destination write strobe, one enabled cycle
- reo  out  16  overflow register O
- skp  out  1  skip pending: next instruction is to be discarded

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. Every state change requires ena=1.
- Reset values: res=0, wre=0, reo=0, skp=0. Internal operand and opcode latches are also 0.
- Latch edge: at the edge with pha==3, capture opc, opa and opb into internal registers.
- Execute edge: at the edge with pha==0, the registered outputs update from the latched values. res/wre are valid while pha==1..3.
- wre is cleared at every enabled edge with pha!=0, so it is high for exactly one enabled cycle per instruction.
- Arithmetic:
  - All results truncate to 16 bits.
  - Shift amounts are the full 16-bit b. A shift amount >=32 gives 0 for both res and O.
- Per-opcode results (res, O update, wre):
  - SET: res=b; O unchanged; wre=1.
  - ADD: res=a+b; O=0x0001 on carry, else 0x0000.
  - SUB: res=a-b; O=0xFFFF on borrow, else 0x0000.
  - MUL: res=(a*b)[15:0]; O=(a*b)[31:16].
  - DIV: res=a/b; O=((a<<16)/b)[15:0]. If b==0: res=0, O=0.
  - MOD: res=a%b. If b==0: res=0. O unchanged.
  - SHL: res=(a<<b)[15:0]; O=((a<<b)>>16)[15:0].
  - SHR: res=a>>b; O=((a<<16)>>b)[15:0].
  - AND/BOR/XOR: bitwise; O unchanged; wre=1.
  - IFE/IFN/IFG/IFB: wre=0; res=0; O unchanged. Tests are a==b, a!=b, a>b (unsigned), (a&b)!=0. When the test fails, skp<=1.
  - opc 0 (non-basic): wre=0, res=a, O unchanged, skp unaffected.
- Skip:
  - If skp==1 at an execute edge, the current instruction is discarded: wre=0, O unchanged, res unchanged, and skp<=0. An IFx instruction being skipped is not evaluated.
  - There is no chaining: a skipped IF never sets skp.
- Explicit O write:
  - If owe==1 at the execute edge and the instruction is not skipped, reo<=odi. This overrides the arithmetic O update of the same instruction.
- ena=0 mid-instruction: all registers hold, including wre. The downstream stage qualifies wre with ena.
- Reset mid-instruction: all outputs return to reset values on the next edge. A pending skip is lost.

Decomposition:
- Shared package dcpu16_pkg:
  - Opcode localparams OPC_NBI..OPC_IFB (4-bit).
  - Phase constants PHA_0..PHA_3.
  - Special operand code O_REG=6'h1D.
- Sub-module dcpu16_alu_arith: purely combinational. Takes (opc, a, b) and returns (res, ovf, ovf_we, cond_true, wr_en).
- The top level holds the latches, O, skp and wre sequencing.

Test Plan:
- Reset, then ADD a=0xFFFF b=0x0002 -> res=0x0001, wre pulses once at pha==1, reo=0x0001.
- SUB a=0x0001 b=0x0002 -> res=0xFFFF, reo=0xFFFF; a following AND leaves reo=0xFFFF.
- MUL a=0x1234 b=0x0100 -> res=0x3400, reo=0x0012. DIV a=0x0001 b=0x0002 -> res=0, reo=0x8000. DIV b=0 -> res=0, reo=0.
- SHL a=0x8001 b=1 -> res=0x0002, reo=0x0001. SHR a=0x0003 b=1 -> res=0x0001, reo=0x8000. SHL b=40 -> res=0, reo=0.
- IFE a=1 b=2 -> skp=1, wre=0. Next SET is suppressed (wre=0) and skp clears. An IFN that is itself skipped leaves skp=0.
- ADD with owe=1, odi=0x5555 -> reo=0x5555. With ena held low for 3 cycles mid-instruction, res/reo/wre/skp hold and then resume correctly.
